// File: rtl/scrambler_config_writer.sv
// Writes the 34-byte scrambler config image (mode, 256-bit seed, XOR checksum)
// into a 64x8 RAM and optionally reads it back to flag any mismatch.
module scrambler_config_writer #(
    parameter bit VERIFY       = 1'b1,
    parameter int READ_LATENCY = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic         mode_in,
    input  logic [255:0] seed_in,
    output logic         busy,
    output logic         done,
    output logic         verify_error,
    output logic [5:0]   address,
    output logic [7:0]   data,
    output logic         wren,
    input  logic [7:0]   q
);

    localparam logic [5:0] LAST = 6'd33;
    localparam logic [5:0] RL   = 6'(READ_LATENCY);

    typedef enum logic [1:0] {IDLE, WRITE, READ, FINISH} state_t;

    state_t           state;
    logic             mode_r;
    logic [255:0]     seed_r;
    logic [5:0]       idx;
    logic [5:0]       rcyc;
    logic [33:0][7:0] img;

    // Image is always derived from the latched copy, so live inputs never leak in.
    always_comb begin
        logic [7:0] x;
        img    = '0;
        x      = {7'b0, mode_r};
        img[0] = x;
        for (int k = 1; k <= 32; k++) begin
            img[k] = seed_r[8*k-8 +: 8];
            x      = x ^ seed_r[8*k-8 +: 8];
        end
        img[33] = x;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            verify_error <= 1'b0;
            address      <= '0;
            data         <= '0;
            wren         <= 1'b0;
            mode_r       <= 1'b0;
            seed_r       <= '0;
            idx          <= '0;
            rcyc         <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mode_r       <= mode_in;
                        seed_r       <= seed_in;
                        verify_error <= 1'b0;
                        busy         <= 1'b1;
                        wren         <= 1'b1;
                        address      <= '0;
                        data         <= {7'b0, mode_in};
                        idx          <= '0;
                        state        <= WRITE;
                    end
                end
                WRITE: begin
                    if (idx == LAST) begin
                        wren <= 1'b0;
                        if (VERIFY) begin
                            address <= '0;
                            rcyc    <= '0;
                            state   <= READ;
                        end else begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= FINISH;
                        end
                    end else begin
                        idx     <= idx + 6'd1;
                        address <= idx + 6'd1;
                        data    <= img[idx + 6'd1];
                    end
                end
                READ: begin
                    // q seen at the end of read cycle rcyc belongs to address rcyc-RL
                    if (rcyc >= RL && q != img[rcyc - RL])
                        verify_error <= 1'b1;
                    if (rcyc == LAST + RL) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= FINISH;
                    end else begin
                        rcyc    <= rcyc + 6'd1;
                        address <= (rcyc >= LAST) ? LAST : rcyc + 6'd1;
                    end
                end
                FINISH: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/scrambler_config_writer.md
Name: scrambler_config_writer

Overview:
- Writes the scrambler configuration image (mode + 256-bit seed + checksum) into the 64x8 config memory, byte by byte.
- It is the write-side counterpart of the ROM config reader: it produces exactly the image the reader consumes.
- Optionally reads the image back and compares it, flagging any mismatch.
- Sits between the host/key-management logic and a dual-purpose 64x8 RAM (address, data, wren, q).

Parameters:
- VERIFY, 1, when 1 a read-back compare pass runs after the write pass; when 0 it is skipped.
- READ_LATENCY, 1, cycles from address presented to valid q (legal: 1 or 2).

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- mode_in  input  1  scrambler mode to store
- seed_in  input  256  seed to store
- busy  output  1  high while writing or verifying
- done  output  1  one-cycle completion pulse
- verify_error  output  1  sticky read-back mismatch flag
- address  output  6  memory address
- data  output  8  memory write data
- wren  output  1  memory write enable
- q  input  8  memory read data

Behaviour:
- Image layout: 34 bytes.
  - addr 0 = {7'b0, mode}.
  - addr 1..32 = seed bytes, seed[8k-1:8k-8] at addr k, so seed[7:0] is at addr 1 and seed[255:248] at addr 32.
  - addr 33 = XOR of bytes 0..32.
  - addrs 34..63 are never touched.
- All outputs are registered. Reset values: busy=0, done=0, verify_error=0, address=0, data=0, wren=0. State = IDLE.
- IDLE:
  - When start=1, latch mode_in and seed_in, clear verify_error, and go to WRITE.
  - start in any other state is ignored; the latched values are not changed.
- WRITE:
  - 34 consecutive cycles with wren=1, address=i, data=byte[i], for i=0..33.
  - The first write cycle is the cycle after start is sampled.
  - busy=1 throughout.
  - After i=33: go to READ if VERIFY=1, else go to DONE.
- READ (VERIFY=1 only):
  - wren=0. Present address=0..33 on consecutive cycles, then hold address at 33 for READ_LATENCY further cycles.
  - The q sampled READ_LATENCY cycles after address j was presented is compared with byte[j]. Any inequality sets verify_error, which stays set until the next accepted start.
  - The state lasts 34+READ_LATENCY cycles, then goes to DONE.
- DONE:
  - done=1 and busy=0 for exactly one cycle, wren=0, then IDLE.
  - verify_error is valid from the done cycle onward.
- Total cycles from the start-sample edge to the done pulse:
  - VERIFY=0: done on cycle 35.
  - VERIFY=1: done on cycle 35+34+READ_LATENCY.
- Checksum is computed from the latched values, never from live inputs. Changing seed_in mid-operation has no effect.
- wren is never asserted outside WRITE; data is don't-care (held) outside WRITE.
- Reset mid-operation: asynchronously return to IDLE with all outputs at reset values. A partially written image is left as-is; no completion pulse.

Test Plan:
- Zero seed, mode=1, VERIFY=1, RAM model with READ_LATENCY=1 -> addr0=0x01, addrs 1..32=0x00, addr33=0x01; done exactly 70 cycles after start; verify_error=0.
- seed[7:0]=0xA5, seed[255:248]=0x3C, all other seed bytes 0x00, mode=0 -> addr1=0xA5, addr32=0x3C, addr33=0x99; 34 wren pulses with contiguous addresses 0..33.
- RAM model forces bit0 of the addr 17 read data to flip -> verify_error=1 on the done cycle and held there; next start with a clean RAM clears it to 0.
- start held high for 10 cycles plus a second start pulse mid-WRITE -> exactly one write sequence, one done pulse; seed_in changed mid-WRITE does not affect the stored image.
- reset_n asserted at WRITE i=10 -> outputs immediately at reset values, no done pulse; a later start writes the full image correctly.
- VERIFY=0 -> no read cycles; done exactly 35 cycles after start; verify_error stays 0 regardless of q.
